// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode encoding, RV32I opcodes and the issue-buffer entry type
package alu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7
  } alu_ctrl_t;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  typedef struct packed {
    alu_ctrl_t       alu_ctr;
    logic [XLEN-1:0] var1;
    logic [XLEN-1:0] var2;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            is_branch;
    logic            br_invert;
    logic            illegal;
  } issue_entry_t;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational decode of one instruction into an issue entry
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic [XLEN-1:0] i_imm,
  output issue_entry_t    o_entry
);
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic       w_arith_ok;
  logic       w_legal;
  logic       w_unused;
  alu_ctrl_t  w_arith;
  assign w_op     = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7b5   = i_instr[30];
  assign w_unused = ^{i_instr[31], i_instr[29:15]};
  // OP-IMM never yields SUB: bit 30 of an ADDI is immediate, not funct7
  assign w_arith = w_f3 == 3'd0 ? ((w_f7b5 && w_op == OPC_OP) ? ALU_SUB : ALU_ADD) :
                   w_f3 == 3'd1 ? ALU_SLL :
                   w_f3 == 3'd2 ? ALU_SLT :
                   w_f3 == 3'd5 ? (w_f7b5 ? ALU_SRA : ALU_SRL) :
                   w_f3 == 3'd6 ? ALU_OR : ALU_AND;
  assign w_arith_ok = w_f3 != 3'd3 && w_f3 != 3'd4;
  always_comb begin
    o_entry           = '0;
    o_entry.pc        = i_pc;
    o_entry.var1      = i_rs1_val;
    o_entry.var2      = i_rs2_val;
    o_entry.rd        = i_instr[11:7];
    o_entry.alu_ctr   = ALU_ADD;
    w_legal           = 1'b1;
    case (w_op)
      OPC_OP: begin
        o_entry.alu_ctr = w_arith;
        w_legal         = w_arith_ok;
      end
      OPC_OPIMM: begin
        o_entry.alu_ctr = w_arith;
        o_entry.var2    = i_imm;
        w_legal         = w_arith_ok;
      end
      OPC_LOAD, OPC_JALR: o_entry.var2 = i_imm;
      OPC_STORE: begin
        o_entry.var2 = i_imm;
        o_entry.rd   = '0;
      end
      OPC_LUI: begin
        o_entry.var1 = '0;
        o_entry.var2 = i_imm;
      end
      OPC_AUIPC, OPC_JAL: begin
        o_entry.var1 = i_pc;
        o_entry.var2 = i_imm;
      end
      OPC_BRANCH: begin
        o_entry.alu_ctr   = w_f3[2] ? ALU_SLT : ALU_SUB;
        o_entry.br_invert = w_f3[2] ^ w_f3[0];
        o_entry.is_branch = 1'b1;
        o_entry.rd        = '0;
        w_legal           = !w_f3[1];
      end
      default: w_legal = 1'b0;
    endcase
    // illegal entries still issue so the trap path downstream can see them
    if (!w_legal) begin
      o_entry.alu_ctr   = ALU_ADD;
      o_entry.rd        = '0;
      o_entry.is_branch = 1'b0;
      o_entry.br_invert = 1'b0;
    end
    o_entry.illegal = !w_legal;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue register for the ALU, two-entry skid buffer with flush
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int ADDR_W = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_rs1_val,
  input  logic [ADDR_W-1:0] in_rs2_val,
  input  logic [ADDR_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_ctr,
  output logic [ADDR_W-1:0] out_var1,
  output logic [ADDR_W-1:0] out_var2,
  output logic [ADDR_W-1:0] out_pc,
  output logic [4:0]        out_rd,
  output logic              out_is_branch,
  output logic              out_br_invert,
  output logic              out_illegal
);
  issue_entry_t w_dec;
  issue_entry_t r_main;
  issue_entry_t r_skid;
  logic         r_main_valid;
  logic         r_skid_valid;
  logic         w_acc;
  logic         w_main_free;
  alu_decode u_decode (
    .i_instr   (in_instr),
    .i_pc      (in_pc),
    .i_rs1_val (in_rs1_val),
    .i_rs2_val (in_rs2_val),
    .i_imm     (in_imm),
    .o_entry   (w_dec)
  );
  assign in_ready    = !r_skid_valid;
  assign w_acc       = in_valid && in_ready;
  assign w_main_free = !r_main_valid || out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      r_main_valid <= r_skid_valid || w_acc;
      r_skid_valid <= 1'b0;
      if (r_skid_valid) r_main <= r_skid;
      else if (w_acc) r_main <= w_dec;
    end else if (w_acc) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end
  assign out_valid     = r_main_valid;
  assign out_alu_ctr   = r_main.alu_ctr;
  assign out_var1      = r_main.var1;
  assign out_var2      = r_main.var2;
  assign out_pc        = r_main.pc;
  assign out_rd        = r_main.rd;
  assign out_is_branch = r_main.is_branch;
  assign out_br_invert = r_main.br_invert;
  assign out_illegal   = r_main.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vector table, handshake corner sequences and a randomized queue-model run
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_val = '0;
  logic [31:0] in_rs2_val = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_alu_ctr;
  logic [31:0] out_var1;
  logic [31:0] out_var2;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_is_branch;
  logic        out_br_invert;
  logic        out_illegal;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  alu_issue_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_alu_ctr(out_alu_ctr),
    .out_var1(out_var1), .out_var2(out_var2), .out_pc(out_pc), .out_rd(out_rd),
    .out_is_branch(out_is_branch), .out_br_invert(out_br_invert), .out_illegal(out_illegal)
  );
  typedef struct {
    logic [3:0]  ctr;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        br;
    logic        inv;
    logic        ill;
  } exp_t;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    exp_t        e;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_entry(input string t, input exp_t e);
    chk({t, ".alu_ctr"}, 32'(out_alu_ctr), 32'(e.ctr));
    chk({t, ".rd"}, 32'(out_rd), 32'(e.rd));
    chk({t, ".is_branch"}, 32'(out_is_branch), 32'(e.br));
    chk({t, ".br_invert"}, 32'(out_br_invert), 32'(e.inv));
    chk({t, ".illegal"}, 32'(out_illegal), 32'(e.ill));
    chk({t, ".pc"}, out_pc, e.pc);
    if (!e.ill) begin
      chk({t, ".var1"}, out_var1, e.v1);
      chk({t, ".var2"}, out_var2, e.v2);
    end
  endtask
  // reference decode written directly from the instruction-set table
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    exp_t e;
    int base[8] = '{0, 5, 4, 0, 0, 6, 3, 2};
    int f3 = int'(ins[14:12]);
    int op = int'(ins[6:0]);
    int c = 0;
    e = '{ctr: 4'd0, v1: rs1, v2: rs2, pc: pc, rd: ins[11:7], br: 1'b0, inv: 1'b0, ill: 1'b0};
    if (op == 'h33 || op == 'h13) begin
      if (f3 == 3 || f3 == 4) e.ill = 1'b1;
      c = base[f3] + ((f3 == 5 && ins[30]) ? 1 : 0) + ((f3 == 0 && ins[30] && op == 'h33) ? 1 : 0);
      e.ctr = 4'(c);
      if (op == 'h13) e.v2 = imm;
    end else if (op == 'h03 || op == 'h67) e.v2 = imm;
    else if (op == 'h23) begin e.v2 = imm; e.rd = 5'd0; end
    else if (op == 'h37) begin e.v1 = 32'd0; e.v2 = imm; end
    else if (op == 'h17 || op == 'h6F) begin e.v1 = pc; e.v2 = imm; end
    else if (op == 'h63) begin
      e.rd = 5'd0;
      e.br = 1'b1;
      e.ctr = (f3 >= 4) ? 4'd4 : 4'd1;
      e.inv = (f3 == 1 || f3 == 4);
      if (f3 == 2 || f3 == 3 || f3 == 6 || f3 == 7) e.ill = 1'b1;
    end else e.ill = 1'b1;
    if (e.ill) begin e.ctr = 4'd0; e.rd = 5'd0; e.br = 1'b0; e.inv = 1'b0; end
    return e;
  endfunction
  function automatic vec_t mkv(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [31:0] imm, input int ctr,
                               input logic [31:0] v1, input logic [31:0] v2, input int rd,
                               input int br, input int inv, input int ill);
    vec_t v;
    v.instr = ins; v.pc = pc; v.rs1 = r1; v.rs2 = r2; v.imm = imm;
    v.e = '{ctr: ctr[3:0], v1: v1, v2: v2, pc: pc, rd: rd[4:0], br: br[0], inv: inv[0], ill: ill[0]};
    return v;
  endfunction
  task automatic put(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm);
    in_valid = v; in_instr = ins; in_pc = pc; in_rs1_val = r1; in_rs2_val = r2; in_imm = imm;
  endtask
  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  vec_t vt[$];
  exp_t q[$];
  exp_t ent;
  exp_t z;
  logic fire_in, fire_out;
  logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
  initial begin
    vt.push_back(mkv(32'h002081B3, 32'h100, 32'd5, 32'd7, 32'h0, 0, 32'd5, 32'd7, 3, 0, 0, 0));
    vt.push_back(mkv(32'h40435293, 32'h104, 32'h80000000, 32'd0, 32'h404, 7, 32'h80000000, 32'h404, 5, 0, 0, 0));
    vt.push_back(mkv(32'h00209463, 32'h108, 32'd3, 32'd9, 32'h8, 1, 32'd3, 32'd9, 0, 1, 1, 0));
    vt.push_back(mkv(32'h0020D463, 32'h10C, 32'd3, 32'd9, 32'h8, 4, 32'd3, 32'd9, 0, 1, 0, 0));
    vt.push_back(mkv(32'h00208463, 32'h110, 32'd3, 32'd9, 32'h8, 1, 32'd3, 32'd9, 0, 1, 0, 0));
    vt.push_back(mkv(32'h0020C463, 32'h114, 32'd3, 32'd9, 32'h8, 4, 32'd3, 32'd9, 0, 1, 1, 0));
    vt.push_back(mkv(32'h003140B3, 32'h118, 32'd3, 32'd9, 32'h0, 0, 32'd0, 32'd0, 0, 0, 0, 1));
    vt.push_back(mkv(32'h0020E463, 32'h11C, 32'd3, 32'd9, 32'h8, 0, 32'd0, 32'd0, 0, 0, 0, 1));
    vt.push_back(mkv(32'h40208233, 32'h120, 32'd10, 32'd3, 32'h0, 1, 32'd10, 32'd3, 4, 0, 0, 0));
    vt.push_back(mkv(32'h123453B7, 32'h124, 32'd77, 32'd88, 32'h12345000, 0, 32'd0, 32'h12345000, 7, 0, 0, 0));
    vt.push_back(mkv(32'h00001417, 32'h200, 32'd77, 32'd88, 32'h1000, 0, 32'h200, 32'h1000, 8, 0, 0, 0));
    vt.push_back(mkv(32'h0020A423, 32'h204, 32'h1000, 32'd88, 32'h8, 0, 32'h1000, 32'h8, 0, 0, 0, 0));
    vt.push_back(mkv(32'h0040A483, 32'h208, 32'h2000, 32'd88, 32'h4, 0, 32'h2000, 32'h4, 9, 0, 0, 0));
    vt.push_back(mkv(32'h008000EF, 32'h300, 32'd1, 32'd2, 32'h8, 0, 32'h300, 32'h8, 1, 0, 0, 0));
    vt.push_back(mkv(32'hFFF32293, 32'h304, 32'd5, 32'd2, 32'hFFFFFFFF, 4, 32'd5, 32'hFFFFFFFF, 5, 0, 0, 0));
    vt.push_back(mkv(32'h0020B0B3, 32'h308, 32'd5, 32'd2, 32'h0, 0, 32'd0, 32'd0, 0, 0, 0, 1));
    vt.push_back(mkv(32'hFFFFFFFF, 32'h30C, 32'd5, 32'd2, 32'h0, 0, 32'd0, 32'd0, 0, 0, 0, 1));
    vt.push_back(mkv(32'h40010093, 32'h310, 32'd11, 32'd22, 32'h400, 0, 32'd11, 32'h400, 1, 0, 0, 0));
    vt.push_back(mkv(32'h403150B3, 32'h314, 32'd11, 32'd22, 32'h0, 7, 32'd11, 32'd22, 1, 0, 0, 0));
    vt.push_back(mkv(32'h003150B3, 32'h318, 32'd11, 32'd22, 32'h0, 6, 32'd11, 32'd22, 1, 0, 0, 0));
    vt.push_back(mkv(32'h003170B3, 32'h31C, 32'd11, 32'd22, 32'h0, 2, 32'd11, 32'd22, 1, 0, 0, 0));
    vt.push_back(mkv(32'h003160B3, 32'h320, 32'd11, 32'd22, 32'h0, 3, 32'd11, 32'd22, 1, 0, 0, 0));
    vt.push_back(mkv(32'h003110B3, 32'h324, 32'd11, 32'd22, 32'h0, 5, 32'd11, 32'd22, 1, 0, 0, 0));
    vt.push_back(mkv(32'h003120B3, 32'h328, 32'd11, 32'd22, 32'h0, 4, 32'd11, 32'd22, 1, 0, 0, 0));
    z = '{ctr: 4'd0, v1: 32'd0, v2: 32'd0, pc: 32'd0, rd: 5'd0, br: 1'b0, inv: 1'b0, ill: 1'b0};
    do_reset();
    @(negedge clk);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk_entry("reset", z);
    // directed decode vectors, one instruction per cycle with out_ready high
    out_ready = 1'b1;
    foreach (vt[k]) begin
      @(posedge clk);
      #1 put(1'b1, vt[k].instr, vt[k].pc, vt[k].rs1, vt[k].rs2, vt[k].imm);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d.out_valid", k), 32'(out_valid), 32'd1);
      chk_entry($sformatf("vec%0d", k), vt[k].e);
    end
    // backpressure: A, B buffered, C held off until the drain
    do_reset();
    put(1'b1, 32'h002081B3, 32'h10, 32'hA, 32'd0, 32'd0);
    @(posedge clk);
    #1 put(1'b1, 32'h002081B3, 32'h14, 32'hB, 32'd0, 32'd0);
    @(negedge clk);
    chk("bp.valid_a", 32'(out_valid), 32'd1);
    chk("bp.ready_a", 32'(in_ready), 32'd1);
    chk("bp.var1_a", out_var1, 32'hA);
    @(posedge clk);
    #1 put(1'b1, 32'h002081B3, 32'h18, 32'hC, 32'd0, 32'd0);
    @(negedge clk);
    chk("bp.ready_full", 32'(in_ready), 32'd0);
    chk("bp.var1_frozen", out_var1, 32'hA);
    @(posedge clk);
    @(negedge clk);
    chk("bp.ready_still_full", 32'(in_ready), 32'd0);
    chk("bp.var1_still_frozen", out_var1, 32'hA);
    chk("bp.pc_still_frozen", out_pc, 32'h10);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.drain_b", out_var1, 32'hB);
    chk("bp.ready_after_drain", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp.drain_c_valid", 32'(out_valid), 32'd1);
    chk("bp.drain_c", out_var1, 32'hC);
    @(posedge clk);
    @(negedge clk);
    chk("bp.empty", 32'(out_valid), 32'd0);
    // flush with both entries full and an input offered in the same cycle
    out_ready = 1'b0;
    #1 put(1'b1, 32'h002081B3, 32'h20, 32'h1, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("fl.full_before", 32'(in_ready), 32'd0);
    put(1'b1, 32'h002081B3, 32'h24, 32'hD, 32'd0, 32'd0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl.out_valid", 32'(out_valid), 32'd0);
    chk("fl.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("fl.dropped", 32'(out_valid), 32'd0);
    // reset in the middle of a stream
    out_ready = 1'b0;
    put(1'b1, 32'h40208233, 32'h40, 32'h55, 32'd1, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mr.before", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mr.out_valid", 32'(out_valid), 32'd0);
    chk("mr.in_ready", 32'(in_ready), 32'd1);
    chk_entry("mr", z);
    // randomized run against an in-order queue model of the two buffered entries
    q.delete();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      if (i > 0) begin
        if (flush) q.delete();
        else begin
          if (fire_out) void'(q.pop_front());
          if (fire_in) q.push_back(ent);
        end
      end
      #1;
      in_instr = $urandom;
      in_instr[6:0] = ops[$urandom_range(0, 9)];
      put($urandom_range(0, 3) != 0, in_instr, $urandom, $urandom, $urandom, $urandom);
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 24) == 0;
      @(negedge clk);
      chk("rnd.out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("rnd.in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) chk_entry("rnd", q[0]);
      ent = ref_dec(in_instr, in_pc, in_rs1_val, in_rs2_val, in_imm);
      fire_in = in_valid && q.size() < 2;
      fire_out = out_ready && q.size() > 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
